// File: rtl/coax_pkg.sv
// Shared definitions for the coax transmit path: word width and feeder FSM encoding.
package coax_pkg;

  localparam int COAX_WORD_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    GAP  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/coax_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a write lands one cycle before it is readable at the head.
// A push while full is dropped unless a pop in the same cycle frees the slot.
module coax_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Popping first frees the head slot, so a push in the same cycle is legal when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/coax_tx_feeder.sv
// Feeds queued host words to the coax transmitter: one tx_load pulse per word, at most one every 3 cycles, held off while tx_full.
// Write-to-pulse latency 2 cycles; macro COAX_TX_FEEDER_ERROR_EN adds the sticky overflow flag.
module coax_tx_feeder
  import coax_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_strobe,
  input  logic [COAX_WORD_WIDTH-1:0] write_data,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       tx_load,
  output logic [COAX_WORD_WIDTH-1:0] tx_data,
  input  logic                       tx_full,
  input  logic                       tx_active,
  output logic                       busy
`ifdef COAX_TX_FEEDER_ERROR_EN
  ,
  input  logic                       overflow_clear,
  output logic                       overflow
`endif
);

  feeder_state_t              state_q;
  feeder_state_t              state_d;
  logic                       pop;
  logic                       load_start;
  logic [COAX_WORD_WIDTH-1:0] head_data;

  coax_fifo #(
    .WIDTH (COAX_WORD_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (write_strobe),
    .push_data (write_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    load_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !tx_full) begin
          state_d    = LOAD;
          load_start = 1'b1;
        end
      end
      LOAD: begin
        pop     = 1'b1;
        state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The head is captured on entry to LOAD so tx_data is settled for the whole pulse and held until the next one.
  always_ff @(posedge clk) begin
    if (reset)           tx_data <= '0;
    else if (load_start) tx_data <= head_data;
  end

  assign tx_load = (state_q == LOAD);
  assign busy    = !fifo_empty || tx_active || (state_q != IDLE);

`ifdef COAX_TX_FEEDER_ERROR_EN
  logic dropped;

  // A pop only happens in LOAD, so a full FIFO drops the write only outside LOAD.
  assign dropped = write_strobe && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (reset)               overflow <= 1'b0;
    else if (dropped)        overflow <= 1'b1;
    else if (overflow_clear) overflow <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_coax_tx_feeder.sv
// Randomized and directed bench for coax_tx_feeder against a cycle-level protocol model.
module tb_coax_tx_feeder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       write_strobe = 1'b0;
  logic [9:0] write_data = '0;
  logic       tx_full = 1'b0;
  logic       tx_active = 1'b0;
  logic       fifo_full, fifo_empty, tx_load, busy;
  logic [9:0] tx_data;
`ifdef COAX_TX_FEEDER_ERROR_EN
  logic       overflow_clear = 1'b0;
  logic       overflow;
`endif

  coax_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .write_strobe (write_strobe),
    .write_data   (write_data),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .tx_load      (tx_load),
    .tx_data      (tx_data),
    .tx_full      (tx_full),
    .tx_active    (tx_active),
    .busy         (busy)
`ifdef COAX_TX_FEEDER_ERROR_EN
    ,
    .overflow_clear (overflow_clear),
    .overflow       (overflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Protocol model: a word queue, the cycle of the last pulse, and the previous cycle's view.
  logic [9:0] m_q[$];
  int         cyc = 0;
  int         m_last = -100;
  int         p_size = 0;
  bit         p_txfull = 1'b0;
  bit         p_reset = 1'b1;
  bit         mon_en = 1'b0;
  logic [9:0] m_txd = '0;
  bit         m_ovf = 1'b0;
  bit         exp_load, in_gap, acc, exp_busy;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      exp_load = !p_reset && ((cyc - 1 - m_last) >= 2) && (p_size > 0) && !p_txfull;
      in_gap   = (m_last == cyc - 1);
      if (exp_load) m_txd = m_q[0];
      exp_busy = (m_q.size() > 0) || tx_active || exp_load || in_gap;

      checks++;
      if (tx_load !== exp_load) $display("FAIL mon_tx_load cyc=%0d got=%b exp=%b", cyc, tx_load, exp_load);
      else passes++;
      checks++;
      if (tx_data !== m_txd) $display("FAIL mon_tx_data cyc=%0d got=%h exp=%h", cyc, tx_data, m_txd);
      else passes++;
      checks++;
      if (fifo_empty !== (m_q.size() == 0)) $display("FAIL mon_empty cyc=%0d got=%b size=%0d", cyc, fifo_empty, m_q.size());
      else passes++;
      checks++;
      if (fifo_full !== (m_q.size() == DEPTH)) $display("FAIL mon_full cyc=%0d got=%b size=%0d", cyc, fifo_full, m_q.size());
      else passes++;
      checks++;
      if (busy !== exp_busy) $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
      else passes++;
`ifdef COAX_TX_FEEDER_ERROR_EN
      checks++;
      if (overflow !== m_ovf) $display("FAIL mon_overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
      else passes++;
`endif

      acc = !reset && write_strobe && ((m_q.size() < DEPTH) || exp_load);
`ifdef COAX_TX_FEEDER_ERROR_EN
      if (reset) m_ovf = 1'b0;
      else if (write_strobe && !acc) m_ovf = 1'b1;
      else if (overflow_clear) m_ovf = 1'b0;
`endif
      p_size   = m_q.size();
      p_txfull = tx_full;
      p_reset  = reset;
      if (exp_load) begin
        void'(m_q.pop_front());
        m_last = cyc;
      end
      if (acc) m_q.push_back(write_data);
      if (reset) begin
        m_q.delete();
        m_last = -100;
        m_txd  = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      write_strobe = 1'b0;
    end
  endtask

  task automatic test_reset();
    write_strobe = 1'b1;
    write_data   = 10'h3ff;
    for (int i = 0; i < 3; i++) begin
      tick();
      mon_en    = 1'b1;
      tx_active = (i == 2);
      @(negedge clk);
      checks++;
      if (fifo_empty !== 1'b1) $display("FAIL rst_empty got=%b exp=1", fifo_empty); else passes++;
      checks++;
      if (fifo_full !== 1'b0) $display("FAIL rst_full got=%b exp=0", fifo_full); else passes++;
      checks++;
      if (tx_load !== 1'b0) $display("FAIL rst_tx_load got=%b exp=0", tx_load); else passes++;
      checks++;
      if (tx_data !== 10'h000) $display("FAIL rst_tx_data got=%h exp=000", tx_data); else passes++;
      checks++;
      if (busy !== (i == 2)) $display("FAIL rst_busy got=%b exp=%b", busy, (i == 2)); else passes++;
    end
    tick();
    reset        = 1'b0;
    write_strobe = 1'b0;
    tx_active    = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_empty !== 1'b1) $display("FAIL rst_write_ignored got=%b exp=1", fifo_empty); else passes++;
    idle_cycles(3);
  endtask

  task automatic test_single_word();
    tx_full = 1'b0;
    tick();
    write_strobe = 1'b1;
    write_data   = 10'h155;
    @(negedge clk);
    checks++;
    if (tx_load !== 1'b0) $display("FAIL single_c0 got=%b exp=0", tx_load); else passes++;
    tick();
    write_strobe = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_load !== 1'b0) $display("FAIL single_c1 got=%b exp=0", tx_load); else passes++;
    tick();
    @(negedge clk);
    checks++;
    if (tx_load !== 1'b1) $display("FAIL single_c2_load got=%b exp=1", tx_load); else passes++;
    checks++;
    if (tx_data !== 10'h155) $display("FAIL single_c2_data got=%h exp=155", tx_data); else passes++;
    tick();
    @(negedge clk);
    checks++;
    if (tx_load !== 1'b0) $display("FAIL single_c3_load got=%b exp=0", tx_load); else passes++;
    checks++;
    if (fifo_empty !== 1'b1) $display("FAIL single_c3_empty got=%b exp=1", fifo_empty); else passes++;
    checks++;
    if (tx_data !== 10'h155) $display("FAIL single_c3_hold got=%h exp=155", tx_data); else passes++;
    idle_cycles(3);
  endtask

  task automatic test_back_to_back();
    int         pc[$];
    logic [9:0] pd[$];
    tx_full = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick();
      write_strobe = (c < 3);
      write_data   = 10'(c + 1);
      @(negedge clk);
      if (tx_load) begin
        pc.push_back(c);
        pd.push_back(tx_data);
      end
    end
    checks++;
    if (pc.size() !== 3) $display("FAIL b2b_count got=%0d exp=3", pc.size()); else passes++;
    for (int i = 0; i < pc.size() && i < 3; i++) begin
      checks++;
      if (pd[i] !== 10'(i + 1)) $display("FAIL b2b_data%0d got=%h exp=%h", i, pd[i], 10'(i + 1)); else passes++;
      checks++;
      if (pc[i] !== 2 + 3 * i) $display("FAIL b2b_cycle%0d got=%0d exp=%0d", i, pc[i], 2 + 3 * i); else passes++;
    end
    idle_cycles(2);
  endtask

  task automatic test_backpressure();
    logic [9:0] w0, w1, got;
    int         pulses, lat;
    bit         lat_ok;
    w0 = 10'($urandom);
    w1 = 10'($urandom);
    tick();
    tx_full      = 1'b1;
    write_strobe = 1'b1;
    write_data   = w0;
    tick();
    write_data   = w1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      write_strobe = 1'b0;
      @(negedge clk);
      if (tx_load) pulses++;
    end
    checks++;
    if (pulses !== 0) $display("FAIL bp_no_pulse got=%0d exp=0", pulses); else passes++;
    checks++;
    if (fifo_empty !== 1'b0) $display("FAIL bp_retained got=%b exp=0", fifo_empty); else passes++;
    lat = -1;
    got = '0;
    for (int d = 0; d < 6 && lat < 0; d++) begin
      tick();
      tx_full = 1'b0;
      @(negedge clk);
      if (tx_load) begin
        lat = d;
        got = tx_data;
      end
    end
    lat_ok = (lat >= 1) && (lat <= 2);
    checks++;
    if (lat_ok !== 1'b1) $display("FAIL bp_release_latency got=%0d exp=1..2", lat); else passes++;
    checks++;
    if (got !== w0) $display("FAIL bp_word0 got=%h exp=%h", got, w0); else passes++;
    lat = -1;
    for (int d = 0; d < 6 && lat < 0; d++) begin
      tick();
      @(negedge clk);
      if (tx_load) begin
        lat = d;
        got = tx_data;
      end
    end
    checks++;
    if (got !== w1 || lat < 0) $display("FAIL bp_word1 got=%h exp=%h", got, w1); else passes++;
    idle_cycles(3);
  endtask

  task automatic test_full_wrap();
    logic [9:0] words[9];
    int         got_n;
    for (int r = 0; r < 3; r++) begin
      tick();
      tx_full = 1'b1;
      for (int i = 0; i < 9; i++) begin
        words[i]     = 10'($urandom);
        write_strobe = 1'b1;
        write_data   = words[i];
        tick();
      end
      write_strobe = 1'b0;
      @(negedge clk);
      checks++;
      if (fifo_full !== 1'b1) $display("FAIL wrap%0d_full got=%b exp=1", r, fifo_full); else passes++;
`ifdef COAX_TX_FEEDER_ERROR_EN
      checks++;
      if (overflow !== 1'b1) $display("FAIL wrap%0d_overflow got=%b exp=1", r, overflow); else passes++;
`endif
      got_n = 0;
      for (int c = 0; c < 40 && got_n < 9; c++) begin
        tick();
        tx_full = 1'b0;
`ifdef COAX_TX_FEEDER_ERROR_EN
        overflow_clear = (c == 0);
`endif
        @(negedge clk);
        if (tx_load) begin
          checks++;
          if (got_n >= 8) $display("FAIL wrap%0d_extra got=%h exp=none", r, tx_data);
          else if (tx_data !== words[got_n]) $display("FAIL wrap%0d_data%0d got=%h exp=%h", r, got_n, tx_data, words[got_n]);
          else passes++;
          got_n++;
        end
      end
      checks++;
      if (got_n !== 8) $display("FAIL wrap%0d_count got=%0d exp=8", r, got_n); else passes++;
      checks++;
      if (fifo_empty !== 1'b1) $display("FAIL wrap%0d_drained got=%b exp=1", r, fifo_empty); else passes++;
`ifdef COAX_TX_FEEDER_ERROR_EN
      checks++;
      if (overflow !== 1'b0) $display("FAIL wrap%0d_ovf_clear got=%b exp=0", r, overflow); else passes++;
`endif
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    tx_full = 1'b0;
    tick();
    write_strobe = 1'b1;
    write_data   = 10'h2a5;
    tick();
    write_data   = 10'h15a;
    tick();
    write_strobe = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_load !== 1'b1) $display("FAIL rmo_in_load got=%b exp=1", tx_load); else passes++;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_load !== 1'b0) $display("FAIL rmo_tx_load got=%b exp=0", tx_load); else passes++;
    checks++;
    if (fifo_empty !== 1'b1) $display("FAIL rmo_empty got=%b exp=1", fifo_empty); else passes++;
    checks++;
    if (busy !== tx_active) $display("FAIL rmo_idle_busy got=%b exp=%b", busy, tx_active); else passes++;
    checks++;
    if (tx_data !== 10'h000) $display("FAIL rmo_tx_data got=%h exp=000", tx_data); else passes++;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      if (tx_load) pulses++;
    end
    checks++;
    if (pulses !== 0) $display("FAIL rmo_no_pulse got=%0d exp=0", pulses); else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1200; i++) begin
      tick();
      write_strobe = ($urandom_range(0, 9) < 6);
      write_data   = 10'($urandom);
      tx_full      = ($urandom_range(0, 9) < 4);
      tx_active    = ($urandom_range(0, 1) == 1);
      reset        = ($urandom_range(0, 399) == 0);
`ifdef COAX_TX_FEEDER_ERROR_EN
      overflow_clear = ($urandom_range(0, 15) == 0);
`endif
    end
    tick();
    write_strobe = 1'b0;
    tx_full      = 1'b0;
    tx_active    = 1'b0;
    reset        = 1'b0;
`ifdef COAX_TX_FEEDER_ERROR_EN
    overflow_clear = 1'b0;
`endif
    idle_cycles(3 * DEPTH + 6);
    @(negedge clk);
    checks++;
    if (fifo_empty !== 1'b1) $display("FAIL rand_drained got=%b exp=1", fifo_empty); else passes++;
    checks++;
    if (m_q.size() !== 0) $display("FAIL rand_model_drained got=%0d exp=0", m_q.size()); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_full_wrap();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
